// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_pkg : shared width helpers and pointer increment-with-wrap   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a pointer by one, returning to zero after the last slot.
    function automatic int ptr_inc(input int ptr, input int last);
        return (ptr == last) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_ptr_ctrl_if : handshake/storage bus of the FIFO controller   |
// | Optional FIFO_PTR_CTRL_ALMOST_FLAGS_EN adds almost_full/empty.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fifo_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int Depth = 5
);
    localparam int PtrWidth = ptr_width(Depth);
    localparam int CntWidth = cnt_width(Depth);

    logic                flush;
    logic                wr_valid;
    logic                wr_ready;
    logic                rd_valid;
    logic                rd_ready;
    logic                mem_we;
    logic [PtrWidth-1:0] mem_waddr;
    logic [PtrWidth-1:0] mem_raddr;
    logic [CntWidth-1:0] count;
    logic                full;
    logic                empty;
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
    logic                almost_full;
    logic                almost_empty;
`endif

    modport master (
        output flush, wr_valid, rd_ready,
        input  wr_ready, rd_valid, mem_we, mem_waddr, mem_raddr, count, full, empty
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  flush, wr_valid, rd_ready,
        output wr_ready, rd_valid, mem_we, mem_waddr, mem_raddr, count, full, empty
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

endinterface
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_ptr_wrap : single wrapping pointer with enable and clear     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter  int Depth    = 5,
    localparam int PtrWidth = ptr_width(Depth)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clr,
    input  wire logic                i_en,
    output logic      [PtrWidth-1:0] o_ptr
);
    localparam logic [PtrWidth-1:0] c_LAST = PtrWidth'(Depth - 1);

    logic [PtrWidth-1:0] r_ptr;
    logic [PtrWidth-1:0] w_next;

    assign w_next = PtrWidth'(ptr_inc(int'(r_ptr), int'(c_LAST)));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_ptr_ctrl : pointer/occupancy controller for external storage |
// | Optional FIFO_PTR_CTRL_ALMOST_FLAGS_EN adds AlmostThr and flags.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int Depth = 5
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
    ,
    parameter int AlmostThr = 1
`endif
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int PtrWidth = ptr_width(Depth);
    localparam int CntWidth = cnt_width(Depth);

    if (Depth < 2) begin : g_depth_chk
        $error("fifo_ptr_ctrl: Depth must be at least 2");
    end

    logic [CntWidth-1:0] r_count;
    logic [PtrWidth-1:0] w_wptr;
    logic [PtrWidth-1:0] w_rptr;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_ready;
    logic                w_rd_valid;
    logic                w_wr_fire;
    logic                w_rd_fire;

    assign w_full     = (r_count == CntWidth'(Depth));
    assign w_empty    = (r_count == '0);
    assign w_wr_ready = ~w_full & ~bus.flush;
    assign w_rd_valid = ~w_empty;
    assign w_wr_fire  = bus.wr_valid & w_wr_ready;
    // A read in the flush cycle is dropped; flush clears everything anyway.
    assign w_rd_fire  = w_rd_valid & bus.rd_ready & ~bus.flush;

    fifo_ptr_wrap #(.Depth(Depth)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.flush),
        .i_en  (w_wr_fire),
        .o_ptr (w_wptr)
    );

    fifo_ptr_wrap #(.Depth(Depth)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.flush),
        .i_en  (w_rd_fire),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_count <= '0;
        end else if (w_wr_fire && !w_rd_fire) begin
            r_count <= r_count + CntWidth'(1);
        end else if (!w_wr_fire && w_rd_fire) begin
            r_count <= r_count - CntWidth'(1);
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.mem_we    = w_wr_fire;
    assign bus.mem_waddr = w_wptr;
    assign bus.mem_raddr = w_rptr;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;

`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
    localparam int c_AF_LVL = (AlmostThr > Depth) ? 0 : (Depth - AlmostThr);

    assign bus.almost_full  = (r_count >= CntWidth'(c_AF_LVL));
    assign bus.almost_empty = (r_count <= CntWidth'(AlmostThr));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
`default_nettype none
// Self-checking bench for fifo_ptr_ctrl (Depth=5): directed steps plus a
// randomized phase compared against an occupancy/modulo-pointer model.
module tb_fifo_ptr_ctrl;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.Depth(D)) bus ();

`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
    fifo_ptr_ctrl #(.Depth(D), .AlmostThr(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`else
    fifo_ptr_ctrl #(.Depth(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

    int compared   = 0;
    int mismatched = 0;
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    logic [31:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_wr_ready;
        exp_wr_ready = (m_cnt != D) && !bus.flush;
        chk({tag, ".count"},     32'(bus.count),     32'(m_cnt));
        chk({tag, ".full"},      32'(bus.full),      32'(m_cnt == D));
        chk({tag, ".empty"},     32'(bus.empty),     32'(m_cnt == 0));
        chk({tag, ".wr_ready"},  32'(bus.wr_ready),  32'(exp_wr_ready));
        chk({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(m_cnt != 0));
        chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(bus.wr_valid && exp_wr_ready));
        chk({tag, ".mem_waddr"}, 32'(bus.mem_waddr), 32'(m_wp));
        chk({tag, ".mem_raddr"}, 32'(bus.mem_raddr), 32'(m_rp));
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(m_cnt >= D - 1));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(m_cnt <= 1));
`endif
    endtask

    // One clock: drive, check combinational view, clock, advance the model.
    task automatic cycle(input string tag, input logic fl, input logic wv, input logic rr);
        logic wf, rf;
        bus.flush = fl; bus.wr_valid = wv; bus.rd_ready = rr;
        #1;
        check_all(tag);
        wf = wv && (m_cnt != D) && !fl;
        rf = rr && (m_cnt != 0) && !fl;
        if (rf) rq.push_back(32'(bus.mem_raddr));
        @(posedge clk);
        if (fl) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
        end else begin
            if (wf) begin m_wp = (m_wp + 1) % D; m_cnt++; end
            if (rf) begin m_rp = (m_rp + 1) % D; m_cnt--; end
        end
        #1;
    endtask

    task automatic do_reset(input logic wv, input logic rr);
        rst = 1'b1; bus.flush = 1'b0; bus.wr_valid = wv; bus.rd_ready = rr;
        @(posedge clk);
        m_cnt = 0; m_wp = 0; m_rp = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_seq[7];
        exp_seq = '{0, 1, 2, 3, 4, 0, 1};
        bus.flush = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        @(posedge clk);
        do_reset(1'b0, 1'b0);
        cycle("reset", 1'b0, 1'b0, 1'b0);

        // Fill to capacity: five writes, no reads.
        for (int i = 0; i < 5; i++) cycle("fill", 1'b0, 1'b1, 1'b0);
        bus.wr_valid = 1'b1; #1;
        chk("fill.count5",    32'(bus.count),     32'd5);
        chk("fill.full",      32'(bus.full),      32'd1);
        chk("fill.wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("fill.waddr0",    32'(bus.mem_waddr), 32'd0);
        cycle("full_hold", 1'b0, 1'b1, 1'b0);

        // Seven writes interleaved with seven reads from a clean state.
        cycle("flush0", 1'b1, 1'b0, 1'b0);
        rq.delete();
        cycle("ilv", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle("ilv", 1'b0, 1'b1, 1'b1);
        cycle("ilv", 1'b0, 1'b0, 1'b1);
        chk("ilv.nreads", 32'(rq.size()), 32'd7);
        for (int i = 0; i < 7 && i < rq.size(); i++)
            chk($sformatf("ilv.raddr[%0d]", i), rq[i], 32'(exp_seq[i]));

        // Simultaneous read/write at count 3.
        cycle("flush1", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("pre3", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("both", 1'b0, 1'b1, 1'b1);
        #1;
        chk("both.count3", 32'(bus.count),     32'd3);
        chk("both.waddr",  32'(bus.mem_waddr), 32'd2);
        chk("both.raddr",  32'(bus.mem_raddr), 32'd4);

        // Flush at count 4 with a write offered.
        cycle("to4", 1'b0, 1'b1, 1'b0);
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        chk("af.count4", 32'(bus.almost_full), 32'd1);
`endif
        bus.flush = 1'b1; bus.wr_valid = 1'b1; #1;
        chk("flush.wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("flush.mem_we",   32'(bus.mem_we),   32'd0);
        cycle("flush", 1'b1, 1'b1, 1'b1);
        chk("flush.count0", 32'(bus.count),     32'd0);
        chk("flush.empty",  32'(bus.empty),     32'd1);
        chk("flush.wp0",    32'(bus.mem_waddr), 32'd0);
        chk("flush.rp0",    32'(bus.mem_raddr), 32'd0);

        // Reset at count 2 with a read pending.
        cycle("to1", 1'b0, 1'b1, 1'b0);
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        chk("ae.count1", 32'(bus.almost_empty), 32'd1);
`endif
        cycle("to2", 1'b0, 1'b1, 1'b0);
`ifdef FIFO_PTR_CTRL_ALMOST_FLAGS_EN
        chk("ae.count2", 32'(bus.almost_empty), 32'd0);
        chk("af.count2", 32'(bus.almost_full),  32'd0);
`endif
        do_reset(1'b0, 1'b1);
        #1;
        chk("rst.count0",   32'(bus.count),     32'd0);
        chk("rst.rd_valid", 32'(bus.rd_valid),  32'd0);
        chk("rst.wp0",      32'(bus.mem_waddr), 32'd0);
        chk("rst.rp0",      32'(bus.mem_raddr), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom), 1'($urandom));
            end else begin
                cycle("rand", ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            end
        end
        cycle("final", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
